// File: rtl/mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter
//
// Sequences the MEM-stage data memory and shares it between two requesters:
//   * the pipeline MEM stage (priority requester, stalled until its access ends)
//   * a secondary DMA/loader port (request/grant/done handshake)
// Every access holds the memory strobes for exactly LAT cycles. A starvation
// guard forces a DMA grant after MAX_STARVE consecutive pipeline grants that
// were made while the DMA port was waiting.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   MemRead, MemWrite               pipeline request (level, write wins if both)
//   p_address, p_writedata          pipeline address / store data
//   p_readdata, p_stall             pipeline load data / stage freeze
//   d_req, d_we, d_addr, d_wdata    DMA request and its fields
//   d_gnt, d_done, d_rdata          DMA accept pulse / finish pulse / read data
//   m_memRead, m_memWrite           memory strobes
//   m_address, m_writedata          memory address / write data
//   m_readdata                      memory read data (valid in last ACCESS cycle)
// -----------------------------------------------------------------------------
module mem_access_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LAT        = 2,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] p_address,
    input  logic [DATA_W-1:0] p_writedata,
    output logic [DATA_W-1:0] p_readdata,
    output logic              p_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_memRead,
    output logic              m_memWrite,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata
);

    localparam int ST_W = $clog2(MAX_STARVE + 1);
    localparam logic [3:0]      CNT_INIT   = 4'(LAT - 1);
    localparam logic [ST_W-1:0] STARVE_MAX = ST_W'(MAX_STARVE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ST_W-1:0]   r_starve;
    logic              r_owner_dma;
    logic              r_m_rd;
    logic              r_m_wr;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic [DATA_W-1:0] r_p_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_d_done;

    logic w_p_req;
    logic w_p_is_wr;
    logic w_d_wins;
    logic w_dma_grant;
    logic w_pipe_grant;

    // A simultaneous MemRead/MemWrite is treated as a write.
    assign w_p_req   = MemRead | MemWrite;
    assign w_p_is_wr = MemWrite;

    // DMA wins only when the pipeline is quiet or has starved DMA long enough.
    assign w_d_wins     = d_req & (~w_p_req | (r_starve == STARVE_MAX));
    assign w_dma_grant  = (r_state == S_IDLE) & w_d_wins;
    assign w_pipe_grant = (r_state == S_IDLE) & ~w_d_wins & w_p_req;

    // Grant is visible in the arbitration cycle itself so the DMA master can
    // drop d_req at the following edge; forced low while reset is held.
    assign d_gnt = w_dma_grant & ~reset;

    // Pipeline is released only in the DONE cycle of its own access.
    assign p_stall = w_p_req & ~((r_state == S_DONE) & ~r_owner_dma);

    assign m_memRead   = r_m_rd;
    assign m_memWrite  = r_m_wr;
    assign m_address   = r_m_addr;
    assign m_writedata = r_m_wdata;
    assign p_readdata  = r_p_rdata;
    assign d_rdata     = r_d_rdata;
    assign d_done      = r_d_done;

    // Access sequencer: arbitration, latching, strobe timing and read capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_starve    <= '0;
            r_owner_dma <= 1'b0;
            r_m_rd      <= 1'b0;
            r_m_wr      <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_p_rdata   <= '0;
            r_d_rdata   <= '0;
            r_d_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_d_done <= 1'b0;
                    if (w_dma_grant) begin
                        r_owner_dma <= 1'b1;
                        r_m_rd      <= ~d_we;
                        r_m_wr      <= d_we;
                        r_m_addr    <= d_addr;
                        r_m_wdata   <= d_wdata;
                        r_cnt       <= CNT_INIT;
                        r_starve    <= '0;
                        r_state     <= S_ACCESS;
                    end else if (w_pipe_grant) begin
                        r_owner_dma <= 1'b0;
                        r_m_rd      <= ~w_p_is_wr;
                        r_m_wr      <= w_p_is_wr;
                        r_m_addr    <= p_address;
                        r_m_wdata   <= p_writedata;
                        r_cnt       <= CNT_INIT;
                        r_state     <= S_ACCESS;
                        // Count only grants that made a waiting DMA wait longer.
                        if (d_req) begin
                            if (r_starve != STARVE_MAX) begin
                                r_starve <= r_starve + ST_W'(1);
                            end else begin
                                r_starve <= r_starve;
                            end
                        end else begin
                            r_starve <= '0;
                        end
                    end else begin
                        if (!d_req) begin
                            r_starve <= '0;
                        end else begin
                            r_starve <= r_starve;
                        end
                    end
                end

                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_m_rd  <= 1'b0;
                        r_m_wr  <= 1'b0;
                        r_state <= S_DONE;
                        // Read registers are only refreshed by read accesses.
                        if (r_m_rd) begin
                            if (r_owner_dma) begin
                                r_d_rdata <= m_readdata;
                            end else begin
                                r_p_rdata <= m_readdata;
                            end
                        end else begin
                            r_p_rdata <= r_p_rdata;
                        end
                        r_d_done <= r_owner_dma;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_DONE: begin
                    r_d_done <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: begin
                    r_m_rd   <= 1'b0;
                    r_m_wr   <= 1'b0;
                    r_d_done <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

    localparam int LAT        = 2;
    localparam int MAX_STARVE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    // Main instance (LAT=2)
    logic        MemRead, MemWrite;
    logic [31:0] p_address, p_writedata, p_readdata;
    logic        p_stall;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_gnt, d_done;
    logic        m_memRead, m_memWrite;
    logic [31:0] m_address, m_writedata, m_readdata;

    // Second instance (LAT=1)
    logic        l1_MemRead, l1_MemWrite;
    logic [31:0] l1_p_address, l1_p_writedata, l1_p_readdata;
    logic        l1_p_stall;
    logic        l1_d_req, l1_d_we;
    logic [31:0] l1_d_addr, l1_d_wdata, l1_d_rdata;
    logic        l1_d_gnt, l1_d_done;
    logic        l1_m_memRead, l1_m_memWrite;
    logic [31:0] l1_m_address, l1_m_writedata, l1_m_readdata;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT), .MAX_STARVE(MAX_STARVE)) u_dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .p_address(p_address), .p_writedata(p_writedata),
        .p_readdata(p_readdata), .p_stall(p_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .m_memRead(m_memRead), .m_memWrite(m_memWrite),
        .m_address(m_address), .m_writedata(m_writedata),
        .m_readdata(m_readdata)
    );

    mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1), .MAX_STARVE(MAX_STARVE)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .MemRead(l1_MemRead), .MemWrite(l1_MemWrite),
        .p_address(l1_p_address), .p_writedata(l1_p_writedata),
        .p_readdata(l1_p_readdata), .p_stall(l1_p_stall),
        .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_gnt(l1_d_gnt), .d_done(l1_d_done), .d_rdata(l1_d_rdata),
        .m_memRead(l1_m_memRead), .m_memWrite(l1_m_memWrite),
        .m_address(l1_m_address), .m_writedata(l1_m_writedata),
        .m_readdata(l1_m_readdata)
    );

    // Word memory for the main instance: addresses 0x00/0x10/0x20/0x30.
    logic [31:0] mem [0:3];

    always_comb begin
        if (m_memRead && (m_address < 32'h40)) m_readdata = mem[m_address[5:4]];
        else                                   m_readdata = 32'h0;
    end

    always @(posedge clk) begin
        if (m_memWrite && (m_address < 32'h40)) mem[m_address[5:4]] <= m_writedata;
    end

    // The LAT=1 instance reads an address-derived pattern.
    always_comb l1_m_readdata = l1_m_address ^ 32'hC0FFEE00;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One pipeline access on the main instance, checked end to end.
    task automatic pipe_op(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata);
        int stalls, rd_cyc, wr_cyc;
        MemRead = rd; MemWrite = wr; p_address = addr; p_writedata = wdata;
        #1;
        stalls = 0; rd_cyc = 0; wr_cyc = 0;
        while (p_stall && stalls < 20) begin
            stalls++;
            if (m_memRead)  rd_cyc++;
            if (m_memWrite) wr_cyc++;
            tick();
        end
        if (m_memRead)  rd_cyc++;
        if (m_memWrite) wr_cyc++;
        check_val({tag, "_stall_cycles"}, 32'(stalls), 32'(LAT + 1));
        check_val({tag, "_rd_strobe_cycles"}, 32'(rd_cyc), (rd && !wr) ? 32'(LAT) : 32'd0);
        check_val({tag, "_wr_strobe_cycles"}, 32'(wr_cyc), wr ? 32'(LAT) : 32'd0);
        if (rd && !wr) check_val({tag, "_rdata"}, p_readdata, exp_rdata);
        MemRead = 1'b0; MemWrite = 1'b0;
        tick();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] order [$];
        logic        prev;
        int          cyc, n;
        int          stalls, strobes;
        logic [31:0] a, w;

        reset = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; p_address = 32'h0; p_writedata = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        l1_MemRead = 1'b0; l1_MemWrite = 1'b0; l1_p_address = 32'h0; l1_p_writedata = 32'h0;
        l1_d_req = 1'b0; l1_d_we = 1'b0; l1_d_addr = 32'h0; l1_d_wdata = 32'h0;
        mem[0] = 32'h0; mem[1] = 32'hDEADBEEF; mem[2] = 32'h0; mem[3] = 32'h0;
        tick(); tick();

        // Reset state
        check_val("rst_m_memRead", {31'd0, m_memRead}, 32'd0);
        check_val("rst_m_memWrite", {31'd0, m_memWrite}, 32'd0);
        check_val("rst_m_address", m_address, 32'h0);
        check_val("rst_p_stall", {31'd0, p_stall}, 32'd0);
        check_val("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        check_val("rst_d_done", {31'd0, d_done}, 32'd0);
        check_val("rst_p_readdata", p_readdata, 32'h0);
        check_val("rst_d_rdata", d_rdata, 32'h0);
        reset = 1'b0;
        tick();

        // 1: reset in the middle of a pipeline read
        MemRead = 1'b1; p_address = 32'h10;
        #1;
        check_val("t1_stall_grant", {31'd0, p_stall}, 32'd1);
        tick();
        check_val("t1_strobe_on", {31'd0, m_memRead}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_val("t1_rst_strobe_off", {31'd0, m_memRead}, 32'd0);
        check_val("t1_rst_stall", {31'd0, p_stall}, 32'd1);
        check_val("t1_rst_no_done", {31'd0, d_done}, 32'd0);
        tick();
        check_val("t1_rst_hold_stall", {31'd0, p_stall}, 32'd1);
        reset = 1'b0;
        // A fresh full-length access proves the FSM restarted from IDLE.
        pipe_op("t1_restart", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);

        // 2: plain pipeline read
        pipe_op("t2_read", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);

        // 3: pipeline write, then DMA read of the same word
        pipe_op("t3_write", 1'b0, 1'b1, 32'h20, 32'h12345678, 32'h0);
        check_val("t3_mem_written", mem[2], 32'h12345678);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        #1;
        check_val("t3_gnt_pulse", {31'd0, d_gnt}, 32'd1);
        tick();
        // Changes after the grant must not disturb the latched request.
        d_req = 1'b0; d_we = 1'b1; d_addr = 32'h10;
        #1;
        check_val("t3_gnt_one_cycle", {31'd0, d_gnt}, 32'd0);
        n = 1;
        while (!d_done && n < 20) begin
            tick();
            n++;
        end
        check_val("t3_done_latency", 32'(n), 32'(LAT + 1));
        check_val("t3_d_rdata", d_rdata, 32'h12345678);
        check_val("t3_p_rdata_hold", p_readdata, 32'hDEADBEEF);
        tick();
        check_val("t3_done_one_cycle", {31'd0, d_done}, 32'd0);
        d_we = 1'b0;

        // 4: starvation guard with both requesters held high
        MemRead = 1'b1; p_address = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        #1;
        check_val("t4_pipe_wins_no_gnt", {31'd0, d_gnt}, 32'd0);
        prev = 1'b0; cyc = 0;
        while (order.size() < 10 && cyc < 80) begin
            if (m_memRead && !prev) order.push_back(m_address);
            prev = m_memRead;
            tick();
            cyc++;
        end
        check_val("t4_grant_count", 32'(order.size()), 32'd10);
        for (int i = 0; i < order.size(); i++) begin
            check_val($sformatf("t4_grant%0d", i), order[i], (i % 5 == 4) ? 32'h20 : 32'h10);
        end
        MemRead = 1'b0; d_req = 1'b0;
        repeat (6) tick();

        // 5: MemRead and MemWrite together behave as a write
        pipe_op("t5_rw", 1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 32'h0);
        check_val("t5_mem_written", mem[3], 32'hA5A5A5A5);
        check_val("t5_rdata_hold", p_readdata, 32'hDEADBEEF);
        pipe_op("t5_readback", 1'b1, 1'b0, 32'h30, 32'h0, 32'hA5A5A5A5);

        // 6: LAT=1 sweep (read, write, read)
        for (int i = 0; i < 3; i++) begin
            a = 32'h100 + 32'(i * 4);
            w = 32'h5A000000 + 32'(i);
            l1_MemRead = (i != 1); l1_MemWrite = (i == 1);
            l1_p_address = a; l1_p_writedata = w;
            #1;
            stalls = 0; strobes = 0;
            while (l1_p_stall && stalls < 20) begin
                stalls++;
                if (l1_m_memRead || l1_m_memWrite) begin
                    strobes++;
                    if (l1_m_memWrite) check_val($sformatf("t6_wdata%0d", i), l1_m_writedata, w);
                end
                tick();
            end
            if (l1_m_memRead || l1_m_memWrite) strobes++;
            check_val($sformatf("t6_stall%0d", i), 32'(stalls), 32'd2);
            check_val($sformatf("t6_strobe%0d", i), 32'(strobes), 32'd1);
            if (i != 1) check_val($sformatf("t6_rdata%0d", i), l1_p_readdata, a ^ 32'hC0FFEE00);
            l1_MemRead = 1'b0; l1_MemWrite = 1'b0;
            tick();
        end
        l1_d_req = 1'b1; l1_d_we = 1'b0; l1_d_addr = 32'h200;
        #1;
        check_val("t6_d_gnt", {31'd0, l1_d_gnt}, 32'd1);
        tick();
        l1_d_req = 1'b0;
        n = 1;
        while (!l1_d_done && n < 20) begin
            tick();
            n++;
        end
        check_val("t6_d_done_latency", 32'(n), 32'd2);
        check_val("t6_d_rdata", l1_d_rdata, 32'h200 ^ 32'hC0FFEE00);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
